// File: rtl/ni_pkg.sv
// Flit layout shared by router and network interface.
// A flit is {dest, src, data}, most significant field first.
package ni_pkg;

    localparam int NI_DATA_W = 32;
    localparam int NI_ADDR_W = 2;
    localparam int FLIT_W    = NI_DATA_W + 2 * NI_ADDR_W;

    localparam int DATA_LSB  = 0;
    localparam int DATA_MSB  = NI_DATA_W - 1;
    localparam int SRC_LSB   = NI_DATA_W;
    localparam int SRC_MSB   = NI_DATA_W + NI_ADDR_W - 1;
    localparam int DEST_LSB  = NI_DATA_W + NI_ADDR_W;
    localparam int DEST_MSB  = FLIT_W - 1;

endpackage

// File: rtl/ni_proc_port_if.sv
// Processor-side and router-side signals of the NI port.
// slave: the NI itself; master: the processor/router environment.
interface ni_proc_port_if
    import ni_pkg::*;
#(
    parameter int DATA_W = NI_DATA_W,
    parameter int ADDR_W = NI_ADDR_W
) ();

    localparam int FW = DATA_W + 2 * ADDR_W;

    logic              proc_valid;
    logic [DATA_W-1:0] proc_data;
    logic [ADDR_W-1:0] dest_add;
    logic              mips_ni;
    logic              data_valid;
    logic [DATA_W-1:0] data_out;
    logic [ADDR_W-1:0] src_out;
    logic              reg_en;
    logic [FW-1:0]     flit_out;
    logic              flit_out_valid;
    logic              flit_out_ready;
    logic [FW-1:0]     flit_in;
    logic              flit_in_valid;
    logic              flit_in_ready;
    logic              err_misroute;
    logic [15:0]       tx_cnt;
    logic [15:0]       rx_cnt;

    modport slave (
        input  proc_valid, proc_data, dest_add, reg_en,
               flit_out_ready, flit_in, flit_in_valid,
        output mips_ni, data_valid, data_out, src_out,
               flit_out, flit_out_valid, flit_in_ready,
               err_misroute, tx_cnt, rx_cnt
    );

    modport master (
        output proc_valid, proc_data, dest_add, reg_en,
               flit_out_ready, flit_in, flit_in_valid,
        input  mips_ni, data_valid, data_out, src_out,
               flit_out, flit_out_valid, flit_in_ready,
               err_misroute, tx_cnt, rx_cnt
    );

endinterface

// File: rtl/ni_sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
// Full blocks push even when a pop happens in the same cycle.
module ni_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/ni_proc_port.sv
// NI side of the processor handshake: TX FIFO building single-flit
// packets toward the router, RX FIFO delivering local flits to the core.
module ni_proc_port
    import ni_pkg::*;
#(
    parameter int DATA_W  = NI_DATA_W,
    parameter int ADDR_W  = NI_ADDR_W,
    parameter int NODE_ID = 0,
    parameter int DEPTH   = 4
) (
    input logic            clk,
    input logic            rst_n,
    ni_proc_port_if.slave  bus
);

    localparam int FW     = DATA_W + 2 * ADDR_W;
    localparam int RX_W   = DATA_W + ADDR_W;
    localparam logic [ADDR_W-1:0] ME = ADDR_W'(NODE_ID);

    logic            tx_full, tx_empty, tx_push, tx_pop;
    logic [FW-1:0]   tx_head;
    logic            rx_full, rx_empty, rx_accept, rx_push, rx_pop;
    logic [RX_W-1:0] rx_head;
    logic [ADDR_W-1:0] in_dest;

    assign tx_push   = bus.proc_valid & ~tx_full;
    assign tx_pop    = bus.flit_out_ready & ~tx_empty;
    assign in_dest   = bus.flit_in[FW-1 -: ADDR_W];
    assign rx_accept = bus.flit_in_valid & ~rx_full;
    assign rx_push   = rx_accept & (in_dest == ME);
    assign rx_pop    = bus.reg_en & ~rx_empty;

    assign bus.mips_ni        = ~tx_full;
    assign bus.flit_out_valid = ~tx_empty;
    assign bus.flit_out       = tx_head;
    assign bus.flit_in_ready  = ~rx_full;
    assign bus.data_valid     = ~rx_empty;
    assign bus.data_out       = rx_head[DATA_W-1:0];
    assign bus.src_out        = rx_head[RX_W-1 -: ADDR_W];

    ni_sync_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_push),
        .push_data ({bus.dest_add, ME, bus.proc_data}),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    // Only {src, data} is kept on RX; dest is known to be this node.
    ni_sync_fifo #(.WIDTH(RX_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .push_data (bus.flit_in[RX_W-1:0]),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // Sticky misroute flag and wrapping transfer counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.err_misroute <= 1'b0;
            bus.tx_cnt       <= '0;
            bus.rx_cnt       <= '0;
        end else begin
            if (rx_accept && (in_dest != ME)) bus.err_misroute <= 1'b1;
            if (tx_pop) bus.tx_cnt <= bus.tx_cnt + 16'd1;
            if (rx_pop) bus.rx_cnt <= bus.rx_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ni_proc_port.sv
// Directed self-checking bench for ni_proc_port (NODE_ID = 1).
module tb_ni_proc_port;

    localparam int DW = 32;
    localparam int AW = 2;
    localparam int FW = DW + 2 * AW;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    ni_proc_port_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ni_proc_port #(.DATA_W(DW), .ADDR_W(AW), .NODE_ID(1), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_mips_ni"},   64'(bus.mips_ni), 64'd1);
        check({pfx, "_fin_rdy"},   64'(bus.flit_in_ready), 64'd1);
        check({pfx, "_dvalid"},    64'(bus.data_valid), 64'd0);
        check({pfx, "_fout_vld"},  64'(bus.flit_out_valid), 64'd0);
        check({pfx, "_err"},       64'(bus.err_misroute), 64'd0);
        check({pfx, "_tx_cnt"},    64'(bus.tx_cnt), 64'd0);
        check({pfx, "_rx_cnt"},    64'(bus.rx_cnt), 64'd0);
        check({pfx, "_flit_out"},  64'(bus.flit_out), 64'd0);
        check({pfx, "_data_out"},  64'(bus.data_out), 64'd0);
        check({pfx, "_src_out"},   64'(bus.src_out), 64'd0);
    endtask

    function automatic logic [FW-1:0] mk_flit(input logic [1:0] d,
                                               input logic [1:0] s,
                                               input logic [31:0] v);
        return {d, s, v};
    endfunction

    initial begin
        logic [FW-1:0] exp_flit;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.proc_valid     = 1'b0;
        bus.proc_data      = '0;
        bus.dest_add       = '0;
        bus.reg_en         = 1'b0;
        bus.flit_out_ready = 1'b0;
        bus.flit_in        = '0;
        bus.flit_in_valid  = 1'b0;

        // Reset state
        #12;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // Single TX word: dest 2, src 1 -> 0x9DEADBEEF
        bus.flit_out_ready = 1'b1;
        bus.proc_valid = 1'b1;
        bus.dest_add   = 2'd2;
        bus.proc_data  = 32'hDEADBEEF;
        tick();
        bus.proc_valid = 1'b0;
        check("tx1_valid", 64'(bus.flit_out_valid), 64'd1);
        check("tx1_flit", 64'(bus.flit_out), 64'h9DEADBEEF);
        check("tx1_cnt_before", 64'(bus.tx_cnt), 64'd0);
        tick();
        check("tx1_valid_after", 64'(bus.flit_out_valid), 64'd0);
        check("tx1_cnt", 64'(bus.tx_cnt), 64'd1);

        // TX backpressure: five pushes into depth-4 FIFO
        bus.flit_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("tx_fill_mips_ni%0d", i), 64'(bus.mips_ni),
                  (i < 4) ? 64'd1 : 64'd0);
            bus.proc_valid = 1'b1;
            bus.dest_add   = 2'(i);
            bus.proc_data  = 32'hA0 + 32'(i);
            tick();
        end
        bus.proc_valid = 1'b0;
        check("tx_full_mips_ni", 64'(bus.mips_ni), 64'd0);
        exp_flit = mk_flit(2'd0, 2'd1, 32'hA0);
        check("tx_stall_flit", 64'(bus.flit_out), 64'(exp_flit));
        tick();
        check("tx_stall_stable", 64'(bus.flit_out), 64'(exp_flit));
        bus.flit_out_ready = 1'b1;
        tick();
        check("tx_mips_ni_after_pop", 64'(bus.mips_ni), 64'd1);
        for (int i = 1; i < 4; i++) begin
            exp_flit = mk_flit(2'(i), 2'd1, 32'hA0 + 32'(i));
            check($sformatf("tx_drain_vld%0d", i), 64'(bus.flit_out_valid), 64'd1);
            check($sformatf("tx_drain_flit%0d", i), 64'(bus.flit_out), 64'(exp_flit));
            tick();
        end
        check("tx_drain_empty", 64'(bus.flit_out_valid), 64'd0);
        check("tx_drain_cnt", 64'(bus.tx_cnt), 64'd5);

        // RX single local flit from node 3
        bus.flit_in       = mk_flit(2'd1, 2'd3, 32'h12345678);
        bus.flit_in_valid = 1'b1;
        tick();
        bus.flit_in_valid = 1'b0;
        check("rx1_dvalid", 64'(bus.data_valid), 64'd1);
        check("rx1_data", 64'(bus.data_out), 64'h12345678);
        check("rx1_src", 64'(bus.src_out), 64'd3);
        check("rx1_cnt_before", 64'(bus.rx_cnt), 64'd0);
        bus.reg_en = 1'b1;
        tick();
        check("rx1_dvalid_after", 64'(bus.data_valid), 64'd0);
        check("rx1_cnt", 64'(bus.rx_cnt), 64'd1);
        tick();
        bus.reg_en = 1'b0;
        check("rx_pop_empty_ignored", 64'(bus.rx_cnt), 64'd1);

        // Misrouted flit: consumed, dropped, sticky error
        check("mis_err_before", 64'(bus.err_misroute), 64'd0);
        bus.flit_in       = mk_flit(2'd2, 2'd0, 32'h55555555);
        bus.flit_in_valid = 1'b1;
        tick();
        bus.flit_in_valid = 1'b0;
        check("mis_fin_rdy", 64'(bus.flit_in_ready), 64'd1);
        check("mis_dvalid", 64'(bus.data_valid), 64'd0);
        check("mis_err", 64'(bus.err_misroute), 64'd1);
        tick();
        tick();
        check("mis_err_sticky", 64'(bus.err_misroute), 64'd1);

        // RX full, then simultaneous pop and offered push
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rx_fill_rdy%0d", i), 64'(bus.flit_in_ready), 64'd1);
            bus.flit_in       = mk_flit(2'd1, 2'd0, 32'h100 + 32'(i));
            bus.flit_in_valid = 1'b1;
            tick();
        end
        bus.flit_in_valid = 1'b0;
        check("rx_full_rdy", 64'(bus.flit_in_ready), 64'd0);
        check("rx_full_head", 64'(bus.data_out), 64'h100);
        bus.flit_in       = mk_flit(2'd1, 2'd2, 32'h2FF);
        bus.flit_in_valid = 1'b1;
        bus.reg_en        = 1'b1;
        tick();
        bus.reg_en        = 1'b0;
        check("rx_full_pop_rdy", 64'(bus.flit_in_ready), 64'd1);
        check("rx_full_pop_head", 64'(bus.data_out), 64'h101);
        check("rx_full_pop_cnt", 64'(bus.rx_cnt), 64'd2);
        bus.flit_in       = mk_flit(2'd1, 2'd2, 32'h200);
        tick();
        bus.flit_in_valid = 1'b0;
        check("rx_refill_rdy", 64'(bus.flit_in_ready), 64'd0);
        bus.reg_en = 1'b1;
        check("rx_drain0", 64'(bus.data_out), 64'h101);
        tick();
        check("rx_drain1", 64'(bus.data_out), 64'h102);
        tick();
        check("rx_drain2", 64'(bus.data_out), 64'h103);
        tick();
        check("rx_drain3", 64'(bus.data_out), 64'h200);
        check("rx_drain3_src", 64'(bus.src_out), 64'd2);
        tick();
        bus.reg_en = 1'b0;
        check("rx_drain_empty", 64'(bus.data_valid), 64'd0);
        check("rx_drain_cnt", 64'(bus.rx_cnt), 64'd6);

        // Asynchronous reset with three words in each FIFO
        bus.flit_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.proc_valid    = 1'b1;
            bus.dest_add      = 2'd3;
            bus.proc_data     = 32'hC0 + 32'(i);
            bus.flit_in       = mk_flit(2'd1, 2'd0, 32'hD0 + 32'(i));
            bus.flit_in_valid = 1'b1;
            tick();
        end
        bus.proc_valid    = 1'b0;
        bus.flit_in_valid = 1'b0;
        check("pre_rst_fout_vld", 64'(bus.flit_out_valid), 64'd1);
        check("pre_rst_dvalid", 64'(bus.data_valid), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        #2;
        rst_n = 1'b1;
        bus.flit_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst_fout_vld%0d", i), 64'(bus.flit_out_valid), 64'd0);
            check($sformatf("post_rst_dvalid%0d", i), 64'(bus.data_valid), 64'd0);
        end
        check("post_rst_tx_cnt", 64'(bus.tx_cnt), 64'd0);
        check("post_rst_rx_cnt", 64'(bus.rx_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ni_proc_port.md
Name: ni_proc_port

Overview:
Network-interface side of the processor/NI handshake. The MIPS decode stage raises proc_valid_D with dest_add_D when mips_ni is high, and reads results via data_valid/reg_en; this block terminates both directions. TX path: buffers processor words, then emits single-flit packets {dest, src, data} to the local router port. RX path: buffers router flits addressed to this node and presents them to the processor until consumed.

Parameters:
DATA_W, 32, processor data word width
ADDR_W, 2, node address width (matches dest_add_D)
NODE_ID, 0, this node's address, inserted as src and checked on RX
DEPTH, 4, entries per FIFO (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
proc_valid  in  1  processor word valid (from proc_valid_D)
proc_data  in  DATA_W  ALU result to send
dest_add  in  ADDR_W  destination node (from dest_add_D)
mips_ni  out  1  NI can accept a processor word (TX FIFO not full)
data_valid  out  1  RX word available to processor
data_out  out  DATA_W  RX payload (head of RX FIFO)
src_out  out  ADDR_W  sender node of RX payload
reg_en  in  1  processor consumes current RX word this cycle
flit_out  out  DATA_W+2*ADDR_W  TX flit {dest, NODE_ID, data}, MSB first
flit_out_valid  out  1  TX flit valid to router
flit_out_ready  in  1  router accepts TX flit
flit_in  in  DATA_W+2*ADDR_W  RX flit {dest, src, data}
flit_in_valid  in  1  router flit valid
flit_in_ready  out  1  NI can accept router flit (RX FIFO not full)
err_misroute  out  1  sticky: a flit with dest != NODE_ID arrived
tx_cnt  out  16  flits sent, wraps 0xFFFF->0
rx_cnt  out  16  flits delivered to processor, wraps

Behaviour:
- Reset (rst_n low, async): both FIFOs empty, pointers/counts 0; mips_ni=1, flit_in_ready=1, data_valid=0, flit_out_valid=0, err_misroute=0, tx_cnt=rx_cnt=0. data_out/src_out/flit_out = 0 while empty. Reset mid-transfer discards all buffered words; no partial flit survives.
- TX push: proc_valid & mips_ni -> write {dest_add, NODE_ID, proc_data} at posedge. proc_valid while mips_ni=0 is ignored (decode only issues when mips_ni=1).
- TX latency: word pushed at edge N -> flit_out_valid high after edge N (combinational from registered FIFO, visible in cycle N+1).
- TX pop: flit_out_valid & flit_out_ready. flit_out stays stable while valid & !ready. tx_cnt += 1 per pop.
- RX push: flit_in_valid & flit_in_ready. If flit_in dest == NODE_ID, write {src, data}; otherwise flit is accepted (consumed) but dropped, err_misroute set (sticky until reset).
- RX latency: flit accepted at edge N -> data_valid in cycle N+1.
- RX pop: data_valid & reg_en; rx_cnt += 1. reg_en with data_valid=0 is ignored.
- Full: mips_ni / flit_in_ready = !full, registered-count based; no pass-through when full, even with simultaneous pop (ready rises the cycle after the pop).
- Simultaneous push and pop on a non-full, non-empty FIFO: both occur, count unchanged.
- Pointers are log2(DEPTH) bits, wrap naturally; count is log2(DEPTH)+1 bits.
- TX and RX paths are fully independent; no ordering between them.

Decomposition:
- Shared package ni_pkg: flit field widths/offsets (FLIT_W, DEST_MSB/LSB, SRC_MSB/LSB, DATA_MSB/LSB) so router and NI agree on flit layout.
- One sub-module: ni_sync_fifo (parameters WIDTH, DEPTH; push/pop, full/empty, head output), instantiated twice (TX width FLIT_W, RX width ADDR_W+DATA_W).
- Top holds dest check, error flag, counters and glue.

Test Plan:
- Reset then push proc_data=0xDEADBEEF, dest_add=2, NODE_ID=1, flit_out_ready=1 -> next cycle flit_out=0x9DEADBEEF ({2,1,data}), flit_out_valid=1 for one cycle, tx_cnt=1.
- Hold flit_out_ready=0, push 5 words -> mips_ni=0 after 4th; 5th ignored; release ready -> exactly 4 flits in push order, mips_ni=1 the cycle after first pop.
- flit_in={dest=0,src=3,data=0x12345678}, NODE_ID=0 -> next cycle data_valid=1, data_out=0x12345678, src_out=3; reg_en=1 -> data_valid=0, rx_cnt=1.
- flit_in with dest=2 at NODE_ID=0 -> flit_in_ready stays 1, data_valid stays 0, err_misroute=1 and remains 1 until rst_n low.
- RX FIFO full (4 words, reg_en=0): flit_in_ready=0; assert reg_en and flit_in_valid same cycle -> one pop, no push; flit_in_ready=1 next cycle, next flit accepted.
- Assert rst_n low asynchronously with 3 words in each FIFO mid-cycle -> outputs at reset values immediately, no flit emitted after release, counters 0.
